result_drain: RTL

Drain controller directly downstream of the array's output buffer. After a tile finishes, `result_drain` issues `out_en` pops to the per-column shift-register buffer and captures each row of `LANES` accumulator words. It requantizes every word (rounding arithmetic right shift, signed saturation) and streams rows to the writeback path over a valid/ready interface with full backpressure.

---
 rtl/result_drain_pkg.sv | 16 +
 rtl/result_drain_requant_lane.sv | 39 +++
 rtl/result_drain.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/result_drain_pkg.sv
// Shared constants and FSM encoding for the result drain controller.
package result_drain_pkg;

   localparam int ARRAYWIDTH          = 8;
   localparam int OUTPUT_BUF_DATASIZE = 32;
   localparam int DEF_OUT_W           = 16;
   localparam int DEF_SH_W            = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } drain_state_t;

endpackage

// File: rtl/result_drain_requant_lane.sv
// Combinational requantizer for one lane: rounding arithmetic right shift
// followed by signed saturation to OUT_W bits.
module requant_lane #(
   parameter int ACC_W = 32,
   parameter int OUT_W = 16,
   parameter int SH_W  = 5
) (
   input  logic [ACC_W-1:0] x,
   input  logic [SH_W-1:0]  shift_amt,
   output logic [OUT_W-1:0] y,
   output logic             sat
);

   localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   logic        [ACC_W:0] half_lsb;
   logic signed [ACC_W:0] x_ext;
   logic signed [ACC_W:0] rnd;
   logic signed [ACC_W:0] r;

   // Rounding offset is 2^(s-1) for s>0 and 0 for s==0, so one path covers both.
   always_comb begin
      x_ext    = {x[ACC_W-1], x};
      half_lsb = {{ACC_W{1'b0}}, 1'b1} << shift_amt;
      rnd      = $signed(half_lsb >> 1);
      r        = (x_ext + rnd) >>> shift_amt;
      sat      = 1'b0;
      y        = r[OUT_W-1:0];
      if (r > MAX_V) begin
         y   = MAX_V[OUT_W-1:0];
         sat = 1'b1;
      end else if (r < MIN_V) begin
         y   = MIN_V[OUT_W-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/result_drain.sv
// Drains one tile of rows from the output buffer, requantizes each lane and
// streams rows downstream over valid/ready through a 2-entry FIFO.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_DRAIN | issuing pops while Q + FIFO have room (or a row leaves)
// ST_WAIT  | all pops issued; waiting for the last row to handshake
// ST_DONE  | one-cycle done pulse, back to idle
module result_drain
   import result_drain_pkg::*;
#(
   parameter int LANES = ARRAYWIDTH,
   parameter int ACC_W = OUTPUT_BUF_DATASIZE,
   parameter int ROWS  = 8,
   parameter int OUT_W = DEF_OUT_W,
   parameter int SH_W  = DEF_SH_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [SH_W-1:0]        shift_amt,
   output logic                   buf_out_en,
   input  logic [LANES*ACC_W-1:0] buf_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [LANES*OUT_W-1:0] m_data,
   output logic                   m_last,
   output logic                   busy,
   output logic                   done,
   output logic                   sat_flag
);

   localparam int CNT_W = $clog2(ROWS + 1);
   localparam int ROW_W = LANES * OUT_W;

   drain_state_t     state, state_nxt;
   logic [SH_W-1:0]  shift_q;
   logic [CNT_W-1:0] pop_cnt;
   logic             q_valid;
   logic             q_last;
   logic [ROW_W-1:0] q_data;
   logic [ROW_W-1:0] fifo_data [2];
   logic [1:0]       fifo_last;
   logic             wr_ptr, rd_ptr;
   logic [1:0]       fifo_count;
   logic [ROW_W-1:0] rq_data;
   logic [LANES-1:0] rq_sat;
   logic             start_acc, pop, pop_last, m_hs, fifo_push;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      requant_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W)) u_requant (
         .x         (buf_data[g*ACC_W +: ACC_W]),
         .shift_amt (shift_q),
         .y         (rq_data[g*OUT_W +: OUT_W]),
         .sat       (rq_sat[g])
      );
   end

   assign m_hs       = m_valid & m_ready;
   assign start_acc  = (state == ST_IDLE) & start;
   assign pop_last   = (pop_cnt == CNT_W'(ROWS - 1));
   // Q always drains into the FIFO when there is room; a departing row makes room.
   assign fifo_push  = q_valid & ((fifo_count != 2'd2) | m_hs);
   assign buf_out_en = pop;
   assign m_valid    = (fifo_count != 2'd0);
   assign m_data     = fifo_data[rd_ptr];
   assign m_last     = fifo_last[rd_ptr];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state, pop strobe and status outputs.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            pop  = ((fifo_count + {1'b0, q_valid}) < 2'd2) | m_hs;
            if (pop && pop_last) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            busy = 1'b1;
            if (m_hs && m_last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Per-tile shift latch, pop counter and sticky saturation flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q  <= '0;
         pop_cnt  <= '0;
         sat_flag <= 1'b0;
      end else if (start_acc) begin
         shift_q  <= shift_amt;
         pop_cnt  <= '0;
         sat_flag <= 1'b0;
      end else if (pop) begin
         pop_cnt <= pop_cnt + CNT_W'(1);
         if (|rq_sat) sat_flag <= 1'b1;
      end
   end

   // Q register captures the requantized head row on the pop cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_data  <= '0;
         q_last  <= 1'b0;
      end else if (pop) begin
         q_valid <= 1'b1;
         q_data  <= rq_data;
         q_last  <= pop_last;
      end else if (fifo_push) begin
         q_valid <= 1'b0;
      end
   end

   // Two-entry show-ahead FIFO between Q and the output port.
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last    <= '0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_count   <= 2'd0;
      end else begin
         if (fifo_push) begin
            fifo_data[wr_ptr] <= q_data;
            fifo_last[wr_ptr] <= q_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (m_hs) rd_ptr <= ~rd_ptr;
         case ({fifo_push, m_hs})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule
